mc_control_fsm: RTL and testbench

Multi-cycle sequencer for the MIPS core: replaces single-cycle decode with a state machine that steps the shared ALU, register file and unified instruction/data memory through fetch, decode, execute, memory and write-back phases. It sits between the instruction register (source of `opcode`/`funct`) and the datapath muxes and strobes. Memory accesses use a `mem_ready` handshake, so instructions take a variable number of cycles.

---
 rtl/mc_control_fsm.sv | 192 +++++++++++++++++++
 tb/tb_mc_control_fsm.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/mc_control_fsm.sv
// mc_control_fsm: multi-cycle MIPS sequencer stepping fetch/decode/execute/memory/write-back.
// Optional MC_MEM_TIMEOUT_EN bounds memory waits and traps to ERROR on expiry.
module mc_control_fsm
`ifdef MC_MEM_TIMEOUT_EN
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
)
`endif
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       ir_write,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic       ext_op,
    output logic       jal_en,
    output logic       lui_en,
    output logic       instr_done,
    output logic       illegal,
    output logic       mem_error,
    output logic [3:0] state
);
    localparam logic [5:0] OP_RTYPE = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04,
                           OP_BNE = 6'h05, OP_ADDI = 6'h08, OP_SLTIU = 6'h0B, OP_ANDI = 6'h0C,
                           OP_ORI = 6'h0D, OP_XORI = 6'h0E, OP_LUI = 6'h0F, OP_LW = 6'h23,
                           OP_SW = 6'h2B, FUNCT_JR = 6'h08;

    typedef enum logic [3:0] {
        FETCH = 4'd0, DECODE = 4'd1, MEM_ADDR = 4'd2, MEM_RD = 4'd3, WB_MEM = 4'd4,
        MEM_WR = 4'd5, EXEC_R = 4'd6, WB_R = 4'd7, EXEC_I = 4'd8, WB_I = 4'd9,
        BRANCH = 4'd10, JUMP = 4'd11, JR = 4'd12, TRAP = 4'd13, ERROR = 4'd14
    } state_t;

    state_t state_q, state_d;

    logic is_itype, is_logic_imm, funct_ok;
    assign is_itype     = opcode inside {OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_SLTIU, OP_LUI};
    assign is_logic_imm = opcode inside {OP_ANDI, OP_ORI, OP_XORI};
    assign funct_ok     = funct inside {6'h00, 6'h02, 6'h03, 6'h20, 6'h21, 6'h22, 6'h23,
                                        6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B};

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state_q <= FETCH;
        else        state_q <= state_d;

`ifdef MC_MEM_TIMEOUT_EN
    logic [7:0] wait_q, wait_d;
    logic       timeout;
    // A ready arriving on the limit cycle takes priority over the timeout.
    assign timeout = (state_q inside {FETCH, MEM_RD, MEM_WR}) && !mem_ready &&
                     wait_q == 8'(TIMEOUT_CYCLES - 1);
    assign wait_d  = (state_d != state_q) ? 8'd0 : wait_q + {7'd0, !mem_ready};

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) wait_q <= 8'd0;
        else        wait_q <= wait_d;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH:    state_d = mem_ready ? DECODE : FETCH;
            DECODE:   state_d = (opcode == OP_LW || opcode == OP_SW) ? MEM_ADDR :
                                (opcode == OP_RTYPE) ? ((funct == FUNCT_JR) ? JR : EXEC_R) :
                                is_itype ? EXEC_I :
                                (opcode == OP_BEQ || opcode == OP_BNE) ? BRANCH :
                                (opcode == OP_J || opcode == OP_JAL) ? JUMP : TRAP;
            MEM_ADDR: state_d = (opcode == OP_LW) ? MEM_RD : MEM_WR;
            MEM_RD:   state_d = mem_ready ? WB_MEM : MEM_RD;
            MEM_WR:   state_d = mem_ready ? FETCH : MEM_WR;
            EXEC_R:   state_d = funct_ok ? WB_R : TRAP;
            EXEC_I:   state_d = WB_I;
            WB_MEM, WB_R, WB_I, BRANCH, JUMP, JR: state_d = FETCH;
            TRAP, ERROR: state_d = state_q;
            default:  state_d = FETCH;
        endcase
`ifdef MC_MEM_TIMEOUT_EN
        if (timeout) state_d = ERROR;
`endif
    end

    always_comb begin
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_to_reg = 1'b0;
        reg_dst    = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        pc_source  = 2'b00;
        ext_op     = 1'b1;
        jal_en     = 1'b0;
        lui_en     = 1'b0;
        instr_done = 1'b0;
        case (state_q)
            FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            DECODE:   alu_src_b = 2'b11;
            MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            MEM_RD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
            end
            WB_MEM: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                instr_done = 1'b1;
            end
            MEM_WR: begin
                mem_write  = 1'b1;
                iord       = 1'b1;
                instr_done = mem_ready;
            end
            EXEC_R: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
            end
            WB_R: begin
                reg_dst    = 1'b1;
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            EXEC_I, WB_I: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                alu_op     = (opcode == OP_ADDI || opcode == OP_LUI) ? 2'b00 : 2'b11;
                ext_op     = !is_logic_imm;
                lui_en     = opcode == OP_LUI;
                reg_write  = state_q == WB_I;
                instr_done = state_q == WB_I;
            end
            BRANCH: begin
                alu_src_a  = 1'b1;
                alu_op     = 2'b01;
                pc_source  = 2'b01;
                pc_write   = (opcode == OP_BEQ && zero) || (opcode == OP_BNE && !zero);
                instr_done = 1'b1;
            end
            JUMP: begin
                pc_source  = 2'b10;
                pc_write   = 1'b1;
                reg_write  = opcode == OP_JAL;
                jal_en     = opcode == OP_JAL;
                instr_done = 1'b1;
            end
            JR: begin
                pc_source  = 2'b11;
                pc_write   = 1'b1;
                instr_done = 1'b1;
            end
            default: ;
        endcase
        // Strobes must stay quiet while reset is held, even though FETCH is already decoded.
        mem_read  = mem_read & rst_n;
        mem_write = mem_write & rst_n;
        reg_write = reg_write & rst_n;
        pc_write  = pc_write & rst_n;
        ir_write  = ir_write & rst_n;
    end

    assign illegal = state_q == TRAP;
`ifdef MC_MEM_TIMEOUT_EN
    assign mem_error = state_q == ERROR;
`else
    assign mem_error = 1'b0;
`endif
    assign state = state_q;
endmodule

// File: tb/tb_mc_control_fsm.sv
// tb_mc_control_fsm: directed walk through every instruction class, reset and memory waits.
module tb_mc_control_fsm;
    logic       clk, rst_n, zero, mem_ready;
    logic [5:0] opcode, funct;
    logic       pc_write, ir_write, iord, mem_read, mem_write, mem_to_reg, reg_dst, reg_write;
    logic       alu_src_a, ext_op, jal_en, lui_en, instr_done, illegal, mem_error;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic [3:0] state;
    logic [4:0] strb;
    int n_cmp = 0, n_err = 0, cyc = 0;

    assign strb = {mem_read, mem_write, reg_write, pc_write, ir_write};

`ifdef MC_MEM_TIMEOUT_EN
    mc_control_fsm #(.TIMEOUT_CYCLES(4)) dut (
`else
    mc_control_fsm dut (
`endif
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .pc_write(pc_write), .ir_write(ir_write), .iord(iord),
        .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
        .reg_dst(reg_dst), .reg_write(reg_write), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_source(pc_source), .ext_op(ext_op),
        .jal_en(jal_en), .lui_en(lui_en), .instr_done(instr_done), .illegal(illegal),
        .mem_error(mem_error), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #2;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; mem_ready = 1'b0; zero = 1'b0; opcode = 6'h00; funct = 6'h00;
        repeat (2) tick;
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_strb", 32'(strb), 32'd0);
        chk("rst_flags", 32'({illegal, mem_error, instr_done}), 32'd0);
        chk("rst_bsel", 32'({alu_src_a, alu_src_b, iord}), 32'b0010);
        rst_n = 1'b1; #1;
        chk("fetch_rd", 32'({mem_read, iord}), 32'b10);

        // ADD
        mem_ready = 1'b1; opcode = 6'h00; funct = 6'h20; #1;
        chk("add_c1", 32'({state, ir_write, pc_write, instr_done}), 32'({4'd0, 3'b110}));
        tick; chk("add_c2", 32'({state, alu_src_b, pc_write}), 32'({4'd1, 2'b11, 1'b0}));
        tick; chk("add_c3", 32'({state, alu_src_a, alu_op, reg_write}), 32'({4'd6, 1'b1, 2'b10, 1'b0}));
        tick; chk("add_c4", 32'({state, reg_write, reg_dst, instr_done}), 32'({4'd7, 3'b111}));
        tick; chk("add_end", 32'(state), 32'd0);

        // LW with three wait cycles in MEM_RD
        opcode = 6'h23; cyc = 1;
        tick; tick;
        chk("lw_addr", 32'({state, alu_src_a, alu_src_b}), 32'({4'd2, 1'b1, 2'b10}));
        mem_ready = 1'b0;
        repeat (3) begin
            tick;
            chk("lw_wait", 32'({state, mem_read, iord, instr_done}), 32'({4'd3, 3'b110}));
        end
        tick; mem_ready = 1'b1; #1;
        chk("lw_ready", 32'({state, mem_read, iord}), 32'({4'd3, 2'b11}));
        tick;
        chk("lw_wb", 32'({state, mem_to_reg, reg_write, reg_dst, instr_done}), 32'({4'd4, 4'b1101}));
        chk("lw_cycles", 32'(cyc), 32'd8);
        tick; chk("lw_end", 32'(state), 32'd0);

        // SW
        opcode = 6'h2B;
        tick; tick; tick;
        chk("sw_wr", 32'({state, mem_write, iord, instr_done}), 32'({4'd5, 3'b111}));
        mem_ready = 1'b0; #1;
        chk("sw_wait", 32'({state, mem_write, instr_done}), 32'({4'd5, 2'b10}));
        mem_ready = 1'b1;
        tick; chk("sw_end", 32'(state), 32'd0);

        // BNE taken, then not-taken by flipping zero in the same cycle
        opcode = 6'h05; zero = 1'b0;
        tick; tick;
        chk("bne_taken", 32'({state, pc_write, pc_source, alu_op, instr_done}), 32'({4'd10, 1'b1, 2'b01, 2'b01, 1'b1}));
        zero = 1'b1; #1;
        chk("bne_nt", 32'(pc_write), 32'd0);
        tick; chk("bne_end", 32'(state), 32'd0);

        // BEQ taken
        opcode = 6'h04;
        tick; tick;
        chk("beq_taken", 32'({state, pc_write}), 32'({4'd10, 1'b1}));
        zero = 1'b0;
        tick;

        // JR
        opcode = 6'h00; funct = 6'h08;
        tick; tick;
        chk("jr", 32'({state, pc_source, pc_write, instr_done}), 32'({4'd12, 2'b11, 2'b11}));
        tick;

        // ANDI
        opcode = 6'h0C;
        tick; tick;
        chk("andi_ex", 32'({state, alu_op, ext_op, alu_src_b, lui_en}), 32'({4'd8, 2'b11, 1'b0, 2'b10, 1'b0}));
        tick;
        chk("andi_wb", 32'({state, reg_write, reg_dst, alu_op, ext_op, instr_done}), 32'({4'd9, 2'b10, 2'b11, 2'b01}));
        tick;

        // LUI
        opcode = 6'h0F;
        tick; tick;
        chk("lui_ex", 32'({state, alu_op, ext_op, lui_en}), 32'({4'd8, 2'b00, 2'b11}));
        tick; tick;
        chk("lui_end", 32'(state), 32'd0);

        // JAL
        opcode = 6'h03;
        tick; tick;
        chk("jal", 32'({state, pc_write, reg_write, jal_en, pc_source, instr_done}), 32'({4'd11, 3'b111, 2'b10, 1'b1}));
        tick;

        // R-type with unsupported funct traps from EXEC_R
        opcode = 6'h00; funct = 6'h3F;
        tick; tick; tick;
        chk("bad_funct", 32'({state, illegal, strb}), 32'({4'd13, 1'b1, 5'd0}));
        rst_n = 1'b0; #1;
        chk("trap_rst", 32'({state, illegal}), 32'd0);
        tick; rst_n = 1'b1;

        // Asynchronous reset in the middle of a stalled MEM_RD
        opcode = 6'h23;
        tick; tick; mem_ready = 1'b0; tick;
        chk("mid_rd", 32'({state, mem_read, iord}), 32'({4'd3, 2'b11}));
        rst_n = 1'b0; #1;
        chk("mid_rst", 32'({state, strb, illegal, iord, alu_src_b}), 32'({4'd0, 5'd0, 2'b00, 2'b01}));
        tick;
        chk("mid_rst_hold", 32'({state, strb}), 32'd0);
        rst_n = 1'b1; #1;
        chk("post_rst", 32'({state, mem_read, iord}), 32'({4'd0, 2'b10}));

        // Illegal opcode stays trapped until reset
        mem_ready = 1'b1; opcode = 6'h3F;
        tick; tick;
        chk("trap", 32'({state, illegal, strb}), 32'({4'd13, 1'b1, 5'd0}));
        repeat (100) tick;
        chk("trap_hold", 32'({state, illegal, strb}), 32'({4'd13, 1'b1, 5'd0}));
        rst_n = 1'b0; #1;
        chk("trap_clr", 32'(illegal), 32'd0);
        tick; mem_ready = 1'b0; opcode = 6'h00; rst_n = 1'b1;

`ifdef MC_MEM_TIMEOUT_EN
        repeat (3) tick;
        chk("tmo_before", 32'({state, mem_read, mem_error}), 32'({4'd0, 2'b10}));
        tick;
        chk("tmo_err", 32'({state, mem_error, strb}), 32'({4'd14, 1'b1, 5'd0}));
`else
        repeat (1000) tick;
        chk("no_tmo", 32'({state, mem_read, mem_error}), 32'({4'd0, 2'b10}));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
